fpmul_share_ctrl: RTL and testbench

Arbiter and sequencer that shares one pipelined FPMul datapath (multiplier plus its aux flag generator) between two independent requesters. It accepts operand pairs through valid/ready handshakes and picks between requesters round-robin. It issues at most one operation per cycle into the fixed-latency multiplier pipeline, tags each operation with its requester, and steers each result and its flags into a per-requester response FIFO. Credit counting guarantees that a returning result always has FIFO space, so the multiplier pipeline never stalls.

---
 rtl/fpmul_pkg.sv | 26 ++
 rtl/fpmul_rsp_fifo.sv | 66 ++++++
 rtl/fpmul_share_ctrl.sv | 142 ++++++++++++++
 tb/tb_fpmul_share_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_pkg.sv
// Shared FPMul definitions: datapath widths, aux-flag bit positions and the
// response record that is stored per requester.
package fpmul_pkg;

  localparam int FP_W   = 32;
  localparam int FLAG_W = 11;

  // Aux flag bit positions, MSB first: {AP_ZF .. AB_DNF}
  localparam int AB_DNF    = 0;
  localparam int AB_ZERO   = 1;
  localparam int AB_INF    = 2;
  localparam int AB_NAN    = 3;
  localparam int OVERFLOW  = 4;
  localparam int UNDERFLOW = 5;
  localparam int ROUND     = 6;
  localparam int AP_NANF   = 7;
  localparam int AP_INFF   = 8;
  localparam int AP_DNF    = 9;
  localparam int AP_ZF     = 10;

  typedef struct packed {
    logic [FP_W-1:0]   p;
    logic [FLAG_W-1:0] flags;
  } fpmul_rsp_t;

endpackage

// File: rtl/fpmul_rsp_fifo.sv
// First-word-fall-through response FIFO with a registered head entry.
// Read and write may coincide in any state; a write when full needs a same-cycle read.
module fpmul_rsp_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic             valid_reg;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             rd_fire, wr_fire;

  assign rd_fire = valid_reg & rd_ready;
  assign wr_fire = wr_en & ((count_reg != FULL_CNT) | rd_fire);

  always_comb begin
    count_next = count_reg;
    if (wr_fire && !rd_fire)
      count_next = count_reg + (AW+1)'(1);
    else if (rd_fire && !wr_fire)
      count_next = count_reg - (AW+1)'(1);
    rd_ptr_next = rd_fire ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    // Bypass the array when the entry being written is the next one to be shown
    head_next = (wr_fire && (wr_ptr_reg == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      head_reg   <= '0;
    end else begin
      if (wr_fire)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      valid_reg  <= (count_next != '0);
      if (count_next != '0)
        head_reg <= head_next;
    end
  end

  assign rd_valid = valid_reg;
  assign rd_data  = head_reg;

endmodule

// File: rtl/fpmul_share_ctrl.sv
// Shares one fixed-latency FPMul pipeline between two requesters: round-robin
// issue, tag pipe steering results into per-requester FIFOs, credit-based flow control.
module fpmul_share_ctrl
  import fpmul_pkg::*;
#(
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [FP_W-1:0]   req0_a,
  input  logic [FP_W-1:0]   req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [FP_W-1:0]   req1_a,
  input  logic [FP_W-1:0]   req1_b,
  output logic              mul_valid,
  output logic [FP_W-1:0]   mul_a,
  output logic [FP_W-1:0]   mul_b,
  input  logic [FP_W-1:0]   mul_p,
  input  logic [FLAG_W-1:0] mul_flags,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [FP_W-1:0]   rsp0_p,
  output logic [FLAG_W-1:0] rsp0_flags,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [FP_W-1:0]   rsp1_p,
  output logic [FLAG_W-1:0] rsp1_flags,
  output logic              busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] RESV_MAX = CW'(DEPTH);

  logic [1:0]      req_valid, rsp_valid, rsp_ready, elig, grant;
  logic [FP_W-1:0] req_a [2];
  logic [FP_W-1:0] req_b [2];
  fpmul_rsp_t      rsp_data [2];
  logic            grant_idx;

  logic            last_reg;
  logic            mul_valid_reg, tag_reg;
  logic [FP_W-1:0] mul_a_reg, mul_b_reg;
  logic [LAT-1:0]  pipe_v_reg, pipe_tag_reg;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_a[0]  = req0_a;
  assign req_a[1]  = req1_a;
  assign req_b[0]  = req0_b;
  assign req_b[1]  = req1_b;

  // Round-robin: on a tie the requester that was not granted last wins
  always_comb begin
    grant = elig;
    if (elig == 2'b11)
      grant = last_reg ? 2'b01 : 2'b10;
    grant_idx = grant[1];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic [CW-1:0] resv_reg;
      logic          rsp_fire;

      assign rsp_fire  = rsp_valid[gi] & rsp_ready[gi];
      assign elig[gi]  = req_valid[gi] & (resv_reg < RESV_MAX) & ~rst;

      // One credit per accepted request, returned when its response is taken
      always_ff @(posedge clk) begin
        if (rst)
          resv_reg <= '0;
        else if (grant[gi] ^ rsp_fire)
          resv_reg <= grant[gi] ? resv_reg + CW'(1) : resv_reg - CW'(1);
      end

      fpmul_rsp_fifo #(
        .WIDTH (FP_W + FLAG_W),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (pipe_v_reg[LAT-1] & (pipe_tag_reg[LAT-1] == 1'(gi))),
        .wr_data  ({mul_p, mul_flags}),
        .rd_valid (rsp_valid[gi]),
        .rd_ready (rsp_ready[gi]),
        .rd_data  (rsp_data[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_valid_reg <= 1'b0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      tag_reg       <= 1'b0;
      last_reg      <= 1'b1;
    end else begin
      mul_valid_reg <= |grant;
      if (|grant) begin
        mul_a_reg <= req_a[grant_idx];
        mul_b_reg <= req_b[grant_idx];
        tag_reg   <= grant_idx;
        last_reg  <= grant_idx;
      end
    end
  end

  // Tag pipe mirrors the multiplier latency so each result finds its owner
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v_reg   <= '0;
      pipe_tag_reg <= '0;
    end else begin
      pipe_v_reg[0]   <= mul_valid_reg;
      pipe_tag_reg[0] <= tag_reg;
      for (int k = 1; k < LAT; k++) begin
        pipe_v_reg[k]   <= pipe_v_reg[k-1];
        pipe_tag_reg[k] <= pipe_tag_reg[k-1];
      end
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign mul_valid  = mul_valid_reg;
  assign mul_a      = mul_a_reg;
  assign mul_b      = mul_b_reg;
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_p     = rsp_data[0].p;
  assign rsp0_flags = rsp_data[0].flags;
  assign rsp1_p     = rsp_data[1].p;
  assign rsp1_flags = rsp_data[1].flags;
  assign busy       = (|pipe_v_reg) | mul_valid_reg | (|rsp_valid);

endmodule

// File: tb/tb_fpmul_share_ctrl.sv
// Bench for fpmul_share_ctrl: behavioural LAT-cycle multiplier, queue-based
// scoreboard per requester, directed scenarios plus a randomized run.
module tb_fpmul_share_ctrl;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        mul_valid;
  logic [31:0] mul_a, mul_b, mul_p;
  logic [10:0] mul_flags;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] rsp0_p, rsp1_p;
  logic [10:0] rsp0_flags, rsp1_flags;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpmul_share_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_flags(mul_flags),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p), .rsp1_flags(rsp1_flags),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Normal-range single precision via double arithmetic (product exact, truncated)
  function automatic real f2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'(110 + $urandom_range(0, 30));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Behavioural multiplier: result and flags appear LAT cycles after mul_valid
  logic        mp_v [LAT];
  logic [31:0] mp_p [LAT];
  logic [10:0] mp_f [LAT];
  always @(posedge clk) begin
    mp_v[0] <= mul_valid;
    mp_p[0] <= fmul(mul_a, mul_b);
    mp_f[0] <= mul_a[10:0] ^ mul_b[10:0];
    for (int k = 1; k < LAT; k++) begin
      mp_v[k] <= mp_v[k-1];
      mp_p[k] <= mp_p[k-1];
      mp_f[k] <= mp_f[k-1];
    end
  end
  assign mul_p     = mp_v[LAT-1] ? mp_p[LAT-1] : 32'hDEAD_BEEF;
  assign mul_flags = mp_v[LAT-1] ? mp_f[LAT-1] : 11'h555;

  // Scoreboard: outstanding ops per requester == credits in use
  logic [42:0] exp_q [2][$];
  int          grant_log [$];
  logic [10:0] flag_log [$];
  int          acc_cnt [2];
  int          last_m = 1;
  logic        log_en = 1'b0;

  always @(negedge clk) begin : mon
    logic [1:0]  rv, rr, sv, sr, eexp;
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic [31:0] sp [2];
    logic [10:0] sf [2];
    logic [42:0] e;
    rv = {req1_valid, req0_valid};
    rr = {req1_ready, req0_ready};
    sv = {rsp1_valid, rsp0_valid};
    sr = {rsp1_ready, rsp0_ready};
    ra[0] = req0_a; ra[1] = req1_a; rb[0] = req0_b; rb[1] = req1_b;
    sp[0] = rsp0_p; sp[1] = rsp1_p; sf[0] = rsp0_flags; sf[1] = rsp1_flags;
    if (rst) begin
      exp_q[0].delete();
      exp_q[1].delete();
      last_m = 1;
      acc_cnt[0] = 0;
      acc_cnt[1] = 0;
      check("ready_in_reset", 64'(rr), 64'(0));
    end else begin
      for (int i = 0; i < 2; i++)
        eexp[i] = rv[i] && (exp_q[i].size() < DEPTH);
      if (eexp == 2'b11)
        eexp = (last_m == 1) ? 2'b01 : 2'b10;
      check("ready", 64'(rr), 64'(eexp));
      for (int i = 0; i < 2; i++) begin
        if (rv[i] && rr[i]) begin
          exp_q[i].push_back({fmul(ra[i], rb[i]), ra[i][10:0] ^ rb[i][10:0]});
          acc_cnt[i]++;
          last_m = i;
          if (log_en) grant_log.push_back(i);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (sr[i] && exp_q[i].size() == 0) begin
          check($sformatf("rsp%0d_unexpected", i), 64'(sv[i]), 64'(0));
        end else if (sv[i] && sr[i]) begin
          e = exp_q[i].pop_front();
          check($sformatf("rsp%0d_p", i), 64'(sp[i]), 64'(e[42:11]));
          check($sformatf("rsp%0d_flags", i), 64'(sf[i]), 64'(e[10:0]));
          if (i == 0) flag_log.push_back(sf[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 0;
    req1_valid = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req0_valid = 0;
    req1_valid = 0;
    rsp0_ready = 1;
    rsp1_ready = 1;
    repeat (n) tick();
  endtask

  initial begin : stim
    int   n;
    logic saw;

    // Reset values
    do_reset();
    check("rst_mul_valid", 64'(mul_valid), 64'(0));
    check("rst_mul_a", 64'(mul_a), 64'(0));
    check("rst_mul_b", 64'(mul_b), 64'(0));
    check("rst_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'(0));
    check("rst_rsp_p", 64'({rsp1_p, rsp0_p}), 64'(0));
    check("rst_rsp_flags", 64'({rsp1_flags, rsp0_flags}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // Single op: 3.0 * 2.0, total latency LAT+2
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_a = 32'h4040_0000; req0_b = 32'h4000_0000;
    tick();
    req0_valid = 0;
    check("single_accept", 64'(acc_cnt[0]), 64'(1));
    check("single_mul_valid", 64'(mul_valid), 64'(1));
    check("single_mul_a", 64'(mul_a), 64'h4040_0000);
    check("single_mul_b", 64'(mul_b), 64'h4000_0000);
    n = 1; saw = 0;
    while (!rsp0_valid && n < 20) begin
      tick();
      n++;
      saw |= rsp1_valid;
    end
    check("single_latency", 64'(n), 64'(LAT + 2));
    check("single_rsp0_p", 64'(rsp0_p), 64'h40C0_0000);
    check("single_rsp1_quiet", 64'(saw), 64'(0));
    drain(10);

    // Tie: alternating grants starting with requester 0
    do_reset();
    grant_log.delete();
    rsp0_ready = 1; rsp1_ready = 1;
    log_en = 1; req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 8; k++) begin
      req0_a = rand_fp(); req0_b = rand_fp();
      req1_a = rand_fp(); req1_b = rand_fp();
      tick();
    end
    log_en = 0;
    drain(12);
    check("tie_count", 64'(grant_log.size()), 64'(8));
    for (int k = 0; k < grant_log.size(); k++)
      check($sformatf("tie_grant%0d", k), 64'(grant_log[k]), 64'(k % 2));

    // Backpressure and credit boundary
    do_reset();
    rsp0_ready = 0; rsp1_ready = 1; req0_valid = 1;
    repeat (12) begin
      req0_a = rand_fp(); req0_b = rand_fp();
      tick();
    end
    check("bp_accepts", 64'(acc_cnt[0]), 64'(4));
    check("bp_ready_low", 64'(req0_ready), 64'(0));
    rsp0_ready = 1;
    #1;
    check("boundary_rsp_valid", 64'(rsp0_valid), 64'(1));
    check("boundary_same_cycle", 64'(req0_ready), 64'(0));
    tick();
    check("boundary_next_cycle", 64'(req0_ready), 64'(1));
    rsp0_ready = 0;
    repeat (6) tick();
    check("bp_one_more", 64'(acc_cnt[0]), 64'(5));
    check("bp_ready_low2", 64'(req0_ready), 64'(0));
    drain(16);

    // Flags passthrough
    do_reset();
    flag_log.delete();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_a = 32'h3F80_07FF; req0_b = 32'h3F80_0000;
    tick();
    req0_a = 32'h3F80_0001;
    tick();
    drain(12);
    check("flags_count", 64'(flag_log.size()), 64'(2));
    if (flag_log.size() == 2) begin
      check("flags_first", 64'(flag_log[0]), 64'h7FF);
      check("flags_second", 64'(flag_log[1]), 64'h001);
    end

    // Reset mid-flight
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1;
    repeat (3) begin
      req0_a = rand_fp(); req0_b = rand_fp();
      tick();
    end
    req0_valid = 0; rst = 1;
    tick();
    rst = 0;
    check("mid_rst_mul_valid", 64'(mul_valid), 64'(0));
    check("mid_rst_mul_ab", 64'({mul_a, mul_b}), 64'(0));
    check("mid_rst_rsp", 64'({rsp1_valid, rsp0_valid, rsp1_p, rsp0_p}), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    saw = 0;
    repeat (12) begin
      tick();
      saw |= rsp0_valid | rsp1_valid | busy;
    end
    check("mid_rst_quiet", 64'(saw), 64'(0));

    // Randomized traffic
    do_reset();
    repeat (400) begin
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      req0_a = rand_fp(); req0_b = rand_fp();
      req1_a = rand_fp(); req1_b = rand_fp();
      rsp0_ready = ($urandom_range(0, 99) < 65);
      rsp1_ready = ($urandom_range(0, 99) < 65);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check("rand_busy_idle", 64'(busy), 64'(0));
    check("rand_queues_empty", 64'(exp_q[0].size() + exp_q[1].size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
